// File: rtl/bit_packer_pkg.sv
// rtl/bit_packer_pkg.sv - shared types and helpers for the bit packer
package bit_packer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/packer_shift_merge.sv
// rtl/packer_shift_merge.sv - combinational mask/shift/merge of one field into the accumulator
module packer_shift_merge #(
  parameter int WIDTH     = 64,
  parameter int LEN_WIDTH = 7
) (
  input  logic [WIDTH-1:0]     acc,
  input  logic [LEN_WIDTH-2:0] fill,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [LEN_WIDTH-1:0] in_len,
  output logic [WIDTH-1:0]     merged,
  output logic [WIDTH-1:0]     remainder,
  output logic [LEN_WIDTH-2:0] new_fill,
  output logic                 complete
);

  localparam int AW = LEN_WIDTH + 1;
  localparam logic [AW-1:0] W_A = AW'(WIDTH);

  logic [AW-1:0]    len_c;
  logic [AW-1:0]    fill_a;
  logic [AW-1:0]    sum;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] masked;

  // Shifting by WIDTH yields zero, which covers len 0 masks and the fill 0 remainder.
  always_comb begin
    fill_a    = AW'(fill);
    len_c     = (AW'(in_len) > W_A) ? W_A : AW'(in_len);
    mask      = {WIDTH{1'b1}} >> (W_A - len_c);
    masked    = in_data & mask;
    merged    = acc | (masked << fill);
    remainder = masked >> (W_A - fill_a);
    sum       = fill_a + len_c;
    complete  = (sum >= W_A);
    new_fill  = complete ? (LEN_WIDTH-1)'(sum - W_A) : (LEN_WIDTH-1)'(sum);
  end

endmodule

// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - packs variable-length fields LSB-first into words for the wide FIFO side
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int LEN_WIDTH = log2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [LEN_WIDTH-1:0] in_len,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 flush_done,
  input  logic                 fifo_full,
  output logic                 push,
  output logic [WIDTH-1:0]     d,
  output logic [LEN_WIDTH-2:0] fill
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [LEN_WIDTH-2:0] fill_q, fill_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_reg_q, out_reg_d;

  logic [WIDTH-1:0]     merged;
  logic [WIDTH-1:0]     remainder;
  logic [LEN_WIDTH-2:0] new_fill;
  logic                 complete;
  logic                 accept;
  logic                 out_free;

  packer_shift_merge #(
    .WIDTH     (WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_shift_merge (
    .acc       (acc_q),
    .fill      (fill_q),
    .in_data   (in_data),
    .in_len    (in_len),
    .merged    (merged),
    .remainder (remainder),
    .new_fill  (new_fill),
    .complete  (complete)
  );

  assign out_free   = !out_valid_q || !fifo_full;
  assign push       = out_valid_q && !fifo_full;
  assign in_ready   = out_free && (state_q == RUN);
  assign accept     = in_valid && in_ready;
  assign flush_done = (state_q == DONE);
  assign d          = out_reg_q;
  assign fill       = fill_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    out_reg_d   = out_reg_q;
    out_valid_d = out_valid_q && !push;
    case (state_q)
      RUN: begin
        if (accept) begin
          fill_d = new_fill;
          if (complete) begin
            out_reg_d   = merged;
            out_valid_d = 1'b1;
            acc_d       = remainder;
          end else begin
            acc_d = merged;
          end
        end
        if (flush && in_ready) state_d = FLUSH;
      end
      FLUSH: begin
        // Accumulator bits above fill are always zero, so it is already padded.
        if (out_free) begin
          if (fill_q != '0) begin
            out_reg_d   = acc_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            fill_d      = '0;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      acc_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_reg_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_reg_q   <= out_reg_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && in_valid && (in_len > LEN_WIDTH'(WIDTH)))
      $error("@verilog ERROR: in_len %0d exceeds WIDTH %0d, clamped", in_len, WIDTH);
    if (!rst) assert (!(push && fifo_full)) else $error("@verilog ERROR: push while fifo_full");
  end
`endif

endmodule

// File: tb/tb_bit_packer.sv
// tb/tb_bit_packer.sv - scoreboard bench for bit_packer with directed vectors
module tb_bit_packer;

  localparam int WIDTH = 64;
  localparam int LW    = 7;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [LW-1:0]    in_len;
  logic             in_ready;
  logic             flush;
  logic             flush_done;
  logic             fifo_full;
  logic             push;
  logic [WIDTH-1:0] d;
  logic [LW-2:0]    fill;

  int checks;
  int errors;
  logic [WIDTH-1:0] exp_q[$];

  bit_packer #(.WIDTH(WIDTH), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_len     (in_len),
    .in_ready   (in_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .fifo_full  (fifo_full),
    .push       (push),
    .d          (d),
    .fill       (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every push must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && push) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push: got %h expected no push", d);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (d !== e) begin
          errors++;
          $display("FAIL push_word: got %h expected %h", d, e);
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] data, input logic [LW-1:0] len);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_len   = len;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_flush(input logic exp_push, input logic [WIDTH-1:0] word);
    if (exp_push) exp_q.push_back(word);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_early", {63'd0, flush_done}, 64'd0);
    @(negedge clk);
    chk("flush_done", {63'd0, flush_done}, 64'd1);
    chk("flush_push", {63'd0, push}, {63'd0, exp_push});
    @(negedge clk);
    chk("flush_done_pulse", {63'd0, flush_done}, 64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    flush     = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_fill", {58'd0, fill}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_push", {63'd0, push}, 64'd0);
    chk("reset_d", d, 64'd0);
    chk("reset_flush_done", {63'd0, flush_done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Eight bytes form one word.
    exp_q.push_back(64'h0807060504030201);
    for (int i = 1; i <= 8; i++) send(64'(i), 7'd8);
    chk("bytes_fill", {58'd0, fill}, 64'd0);

    // Straddling field with junk above in_len; remainder 0xA flushed out.
    exp_q.push_back(64'hBFFF_FFFF_FFFF_FFFF);
    send(64'hFFFF_FFFF_FFFF_FFFF, 7'd60);
    send(64'h0000_0000_0000_FFAB, 7'd8);
    chk("straddle_fill", {58'd0, fill}, 64'd4);
    do_flush(1'b1, 64'h0000_0000_0000_000A);
    chk("straddle_flush_fill", {58'd0, fill}, 64'd0);

    // Backpressure: first word waits, second word's fields stall behind it.
    fifo_full = 1'b1;
    exp_q.push_back(64'h1817161514131211);
    exp_q.push_back(64'h2827262524232221);
    for (int i = 1; i <= 8; i++) send(64'(8'h10 + i), 7'd8);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_push", {63'd0, push}, 64'd0);
    fork
      begin
        for (int i = 1; i <= 8; i++) send(64'(8'h20 + i), 7'd8);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_push", {63'd0, push}, 64'd0);
          chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #2 fifo_full = 1'b0;
      end
    join
    @(negedge clk);
    chk("bp_fill", {58'd0, fill}, 64'd0);

    // Partial word flush.
    send(64'h5000_0000_0000_0ABC, 7'd12);
    chk("abc_fill", {58'd0, fill}, 64'd12);
    do_flush(1'b1, 64'h0000_0000_0000_0ABC);
    chk("abc_flush_fill", {58'd0, fill}, 64'd0);

    // Empty flush.
    do_flush(1'b0, 64'd0);

    // Zero-length field is a no-op.
    send(64'h3, 7'd3);
    send(64'hFF, 7'd0);
    chk("len0_fill", {58'd0, fill}, 64'd3);
    do_flush(1'b1, 64'h3);

    // Mid-stream async reset with a pending word and fill 20.
    fifo_full = 1'b1;
    send(64'h12345, 7'd20);
    send(64'hDEAD_BEEF_0000_0001, 7'd64);
    chk("pre_rst_fill", {58'd0, fill}, 64'd20);
    chk("pre_rst_ready", {63'd0, in_ready}, 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_fill", {58'd0, fill}, 64'd0);
    chk("async_rst_d", d, 64'd0);
    chk("async_rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    fifo_full = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_push", {63'd0, push}, 64'd0);
    send(64'h5, 7'd3);
    chk("post_rst_fill", {58'd0, fill}, 64'd3);

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
